norm_shift_seq: RTL and testbench

Sequential normalizer: the inverse of the datapath barrel shifter. It accepts a 64-bit operand and shifts it left until the most significant bit is significant, either in unsigned or signed (sign-preserving) mode. It reports the normalized value and the shift count that the barrel shifter needs to undo or reproduce the normalization. It sits beside the shifter in the ALU/FP path and uses valid/ready handshakes on both sides.

---
 rtl/norm_pkg.sv | 15 +
 rtl/norm_step.sv | 42 ++++
 rtl/norm_shift_seq.sv | 114 +++++++++++
 tb/tb_norm_shift_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and constants for the sequential normalizer.
// The FSM state encoding and the coarse step size live here so top and step agree.
package norm_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int CNT_W_DEF   = 7;
    localparam int STEP_COARSE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/norm_step.sv
// Combinational step decision for the normalizer: coarse (8-bit) shift, fine (1-bit) shift or stop.
// Signed mode counts redundant sign copies; unsigned mode counts leading zeros.
module norm_step
    import norm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_signed,
    output logic              o_coarse,
    output logic              o_fine,
    output logic              o_stop,
    output logic [DATA_W-1:0] o_data
);

    logic [STEP_COARSE:0]   w_top9;
    logic [STEP_COARSE-1:0] w_top8;
    logic                   w_coarse_ok;
    logic                   w_fine_ok;

    assign w_top9 = i_data[DATA_W-1 -: STEP_COARSE+1];
    assign w_top8 = i_data[DATA_W-1 -: STEP_COARSE];

    // A coarse step needs at least 8 redundant bits: 9 equal bits signed, 8 zeros unsigned.
    assign w_coarse_ok = i_signed ? ((&w_top9) | ~(|w_top9))
                                  : ~(|w_top8);
    assign w_fine_ok   = i_signed ? (i_data[DATA_W-1] == i_data[DATA_W-2])
                                  : ~i_data[DATA_W-1];

    always_comb begin
        o_coarse = w_coarse_ok;
        o_fine   = ~w_coarse_ok & w_fine_ok;
        o_stop   = ~w_coarse_ok & ~w_fine_ok;
        o_data   = i_data;
        if (w_coarse_ok) begin
            o_data = i_data << STEP_COARSE;
        end else if (w_fine_ok) begin
            o_data = i_data << 1;
        end
    end

endmodule

// File: rtl/norm_shift_seq.sv
// Sequential normalizer: shifts an operand left until its MSB is significant, reporting the shift count.
// One operation in flight; accepts only in IDLE and holds the result in DONE until out_ready.
module norm_shift_seq
    import norm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_zero
);

    localparam logic [CNT_W-1:0] CNT_COARSE = CNT_W'(STEP_COARSE);
    localparam logic [CNT_W-1:0] CNT_FINE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(DATA_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_signed;
    logic               r_zero;
    logic [DATA_W-1:0]  r_out_data;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_zero;

    logic               w_coarse;
    logic               w_fine;
    logic               w_stop;
    logic [DATA_W-1:0]  w_step_data;
    logic               w_accept;
    logic               w_finish;
    logic               w_advance;

    norm_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_data   (r_data),
        .i_signed (r_signed),
        .o_coarse (w_coarse),
        .o_fine   (w_fine),
        .o_stop   (w_stop),
        .o_data   (w_step_data)
    );

    // A zero operand still spends one SCAN cycle so its latency equals an already-normalized one.
    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_finish  = (r_state == SCAN) && (r_zero || w_stop);
    assign w_advance = (r_state == SCAN) && !w_finish && (w_coarse || w_fine);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = SCAN;
            SCAN:    if (w_finish)  w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_data   <= in_data;
            r_cnt    <= '0;
            r_signed <= in_signed;
            r_zero   <= (in_data == '0);
        end else if (w_advance) begin
            r_data   <= w_step_data;
            r_cnt    <= r_cnt + (w_coarse ? CNT_COARSE : CNT_FINE);
        end
    end

    // Result registers load only on entry to DONE, so they stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_cnt  <= '0;
            r_out_zero <= 1'b0;
        end else if (w_finish) begin
            r_out_data <= r_zero ? '0 : r_data;
            r_out_cnt  <= r_zero ? CNT_ZERO : r_cnt;
            r_out_zero <= r_zero;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Scoreboard bench for norm_shift_seq: directed operands with hand-computed results and latencies.
module tb_norm_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [6:0]  out_cnt;
    logic        out_zero;

    typedef struct {
        logic [63:0] d;
        logic [6:0]  c;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    bit   prev_vld = 0;

    norm_shift_seq #(.DATA_W(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency on the first valid cycle, held values every valid cycle, pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) acc_cyc = cyc + 1;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_result: got out_data %h expected no result", out_data);
                end else begin
                    e = sb[0];
                    if (!prev_vld) chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    chk("out_data", out_data, e.d);
                    chk("out_cnt", 64'(out_cnt), 64'(e.c));
                    chk("out_zero", 64'(out_zero), 64'(e.z));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_vld = rst_n && out_valid;
        end
    end

    task automatic send(input logic [63:0] d, input logic s, input logic [63:0] ed,
                        input int ec, input logic ez, input int lat, input bit wait_done);
        int g;
        exp_t e;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1");
        end
        e.d = ed; e.c = 7'(ec); e.z = ez; e.lat = lat;
        sb.push_back(e);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        if (wait_done) begin
            g = 0;
            while (sb.size() != 0 && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 200) begin
                n_chk++;
                n_err++;
                $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_cnt"}, 64'(out_cnt), 64'd0);
        chk({tag, "_out_zero"}, 64'(out_zero), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // operand, signed, expected data, count, zero flag, latency
        send(64'h8000_0000_0000_0000, 0, 64'h8000_0000_0000_0000,  0, 0,  1, 1);
        send(64'h0000_0000_0000_0001, 0, 64'h8000_0000_0000_0000, 63, 0, 15, 1);
        send(64'h00F0_0000_0000_0000, 0, 64'hF000_0000_0000_0000,  8, 0,  2, 1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 63, 0, 15, 1);
        send(64'h0000_0000_0000_0000, 0, 64'h0000_0000_0000_0000, 64, 1,  1, 1);
        send(64'h0000_0000_0000_0000, 1, 64'h0000_0000_0000_0000, 64, 1,  1, 1);
        send(64'h0000_0000_0000_4000, 1, 64'h4000_0000_0000_0000, 48, 0,  7, 1);
        send(64'hFFFF_FFFF_FFFF_C000, 1, 64'h8000_0000_0000_0000, 49, 0,  8, 1);
        send(64'h0123_4567_89AB_CDEF, 0, 64'h91A2_B3C4_D5E6_F780,  7, 0,  8, 1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 1, 64'h7FFF_FFFF_FFFF_FFFF,  0, 0,  1, 1);
        send(64'h0000_0000_0001_0000, 0, 64'h8000_0000_0000_0000, 47, 0, 13, 1);
        send(64'h00F0_0000_0000_0000, 1, 64'h7800_0000_0000_0000,  7, 0,  8, 1);

        // Backpressure: result held 10 cycles, in_valid ignored while busy.
        out_ready = 1'b0;
        send(64'h00F0_0000_0000_0000, 0, 64'hF000_0000_0000_0000,  8, 0,  2, 0);
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (10) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1; in_data = 64'h0000_0000_0000_0001; in_signed = 1'b0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-SCAN discards the operation; a following operand completes normally.
        send(64'h0000_0000_0000_0001, 0, 64'h8000_0000_0000_0000, 63, 0, 15, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk_reset_state("midscan_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("after_reset_idle");
        send(64'h0000_0000_0000_0001, 0, 64'h8000_0000_0000_0000, 63, 0, 15, 1);

        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
